spi_bus_master: RTL and testbench

//  SPI mode-0 initiator that turns local bus requests into the team's 16-bit addr/data SPI frame
//  for the spi2ad_bus responder on a remote board or for loopback.

---
 rtl/spi_bus_master.sv | 256 +++++++++++++++++++++++++
 tb/tb_spi_bus_master.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_master.sv
// SPI mode-0 initiator: sends a {addr, auto_inc, rd_wrn} command word followed by data words in one ss-low frame.
// Optional abort input and abort reporting on err_o are enabled by defining SPI_MASTER_ABORT_EN.
module spi_bus_master #(
    parameter int ADDR_WIDTH  = 14,
    parameter int DATA_WIDTH  = 16,
    parameter int CLK_DIV     = 4,
    parameter int TURN_CYCLES = 8,
    parameter int LEN_WIDTH   = 8
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  req_rd_i,
    input  logic                  req_burst_i,
    input  logic [LEN_WIDTH-1:0]  req_len_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  wdata_valid_i,
    output logic                  wdata_ready_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rdata_valid_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  busy_o,
`ifdef SPI_MASTER_ABORT_EN
    input  logic                  abort_i,
`endif
    output logic                  sck_o,
    output logic                  mosi_o,
    output logic                  ss_o,
    input  logic                  miso_i
);
    localparam int CW  = $clog2(CLK_DIV + TURN_CYCLES + 1);
    localparam int BW  = $clog2(DATA_WIDTH);
    localparam int CNW = LEN_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        CMD    = 3'd2,
        TURN   = 3'd3,
        WAIT_W = 3'd4,
        DATA   = 3'd5,
        HOLD   = 3'd6,
        GAP    = 3'd7
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         div_q;
    logic [BW-1:0]         bit_q;
    logic [DATA_WIDTH-1:0] tx_q, rx_q, rdata_q;
    logic [CNW-1:0]        cnt_q;
    logic                  rd_q, sck_q, mosi_q, rd_pend_q, rdata_valid_q;
    logic                  miso_meta_q, miso_sync_q;
    logic                  ss_q, ss_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                  req_ready_q, req_ready_d, wdata_ready_q, wdata_ready_d;
    logic                  shifting_s, tick_s, turn_done_s, rise_s, fall_s, word_end_s;
    logic                  accept_s, wr_hs_s, last_word_s, abort_s;

    assign shifting_s  = (state_q == CMD) || (state_q == DATA);
    assign tick_s      = (div_q == CW'(CLK_DIV - 1));
    assign turn_done_s = (div_q == CW'(TURN_CYCLES - 1));
    assign rise_s      = shifting_s && tick_s && !sck_q;
    assign fall_s      = shifting_s && tick_s && sck_q;
    assign word_end_s  = fall_s && (bit_q == BW'(DATA_WIDTH - 1));
    assign accept_s    = (state_q == IDLE) && req_valid_i && req_ready_q;
    assign wr_hs_s     = (state_q == WAIT_W) && wdata_valid_i && wdata_ready_q;
    assign last_word_s = (cnt_q == CNW'(1));

`ifdef SPI_MASTER_ABORT_EN
    logic abort_q;
    logic abort_win_s;
    assign abort_win_s = (state_q == CMD) || (state_q == TURN) || (state_q == DATA) || (state_q == WAIT_W);
    assign abort_s     = abort_q || (abort_i && abort_win_s);

    // Sticky abort request; it lives until the frame has returned to IDLE
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            abort_q <= 1'b0;
        end else if (state_q == IDLE) begin
            abort_q <= 1'b0;
        end else if (abort_i && abort_win_s) begin
            abort_q <= 1'b1;
        end
    end
`else
    assign abort_s = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an abort only cuts a frame at a word boundary
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_s) state_d = SETUP; else state_d = IDLE;
            SETUP:   if (tick_s) state_d = CMD; else state_d = SETUP;
            CMD: begin
                if (word_end_s) begin
                    if (abort_s)   state_d = HOLD;
                    else if (rd_q) state_d = TURN;
                    else           state_d = WAIT_W;
                end else begin
                    state_d = CMD;
                end
            end
            TURN: begin
                if (abort_s)          state_d = HOLD;
                else if (turn_done_s) state_d = DATA;
                else                  state_d = TURN;
            end
            WAIT_W: begin
                if (abort_s)      state_d = HOLD;
                else if (wr_hs_s) state_d = DATA;
                else              state_d = WAIT_W;
            end
            DATA: begin
                if (word_end_s) begin
                    if (abort_s || last_word_s) state_d = HOLD;
                    else if (rd_q)              state_d = DATA;
                    else                        state_d = WAIT_W;
                end else begin
                    state_d = DATA;
                end
            end
            HOLD:    if (tick_s) state_d = GAP; else state_d = HOLD;
            GAP:     if (tick_s) state_d = IDLE; else state_d = GAP;
            default: state_d = IDLE;
        endcase
    end

    // Output decode, looking one state ahead so the registered outputs line up with the state
    always_comb begin
        ss_d          = (state_d == IDLE) || (state_d == GAP);
        busy_d        = (state_d != IDLE);
        done_d        = (state_q == GAP) && (state_d == IDLE);
        err_d         = done_d && abort_s;
        req_ready_d   = (state_q == IDLE) && (state_d == IDLE);
        wdata_ready_d = (state_d == WAIT_W);
    end

    // Registered control outputs
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            ss_q          <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            req_ready_q   <= 1'b1;
            wdata_ready_q <= 1'b0;
        end else begin
            ss_q          <= ss_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            req_ready_q   <= req_ready_d;
            wdata_ready_q <= wdata_ready_d;
        end
    end

    // Two-flop synchroniser for the MISO pin
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
        end else begin
            miso_meta_q <= miso_i;
            miso_sync_q <= miso_meta_q;
        end
    end

    // Bit timing, shift registers and word counting
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            div_q         <= {CW{1'b0}};
            bit_q         <= {BW{1'b0}};
            tx_q          <= {DATA_WIDTH{1'b0}};
            rx_q          <= {DATA_WIDTH{1'b0}};
            rdata_q       <= {DATA_WIDTH{1'b0}};
            cnt_q         <= {CNW{1'b0}};
            rd_q          <= 1'b0;
            sck_q         <= 1'b0;
            mosi_q        <= 1'b0;
            rd_pend_q     <= 1'b0;
            rdata_valid_q <= 1'b0;
        end else begin
            if ((state_d != state_q) || (state_q == IDLE) || (state_q == WAIT_W) || (shifting_s && tick_s)) begin
                div_q <= {CW{1'b0}};
            end else begin
                div_q <= div_q + CW'(1);
            end

            if (accept_s) begin
                tx_q  <= {req_addr_i, req_burst_i, req_rd_i};
                rd_q  <= req_rd_i;
                cnt_q <= req_burst_i ? ({1'b0, req_len_i} + CNW'(1)) : CNW'(1);
                bit_q <= {BW{1'b0}};
            end else if (wr_hs_s) begin
                tx_q <= wdata_i;
            end else if (word_end_s) begin
                tx_q  <= {DATA_WIDTH{1'b0}};
                bit_q <= {BW{1'b0}};
                if (state_q == DATA) begin
                    cnt_q <= cnt_q - CNW'(1);
                end
            end else if (fall_s) begin
                tx_q  <= {tx_q[DATA_WIDTH-2:0], 1'b0};
                bit_q <= bit_q + BW'(1);
            end

            // MOSI only moves while SCK is low: at SETUP end, on a write load, or on a falling edge
            if ((state_q == SETUP) && tick_s) begin
                mosi_q <= tx_q[DATA_WIDTH-1];
            end else if (wr_hs_s) begin
                mosi_q <= wdata_i[DATA_WIDTH-1];
            end else if (word_end_s) begin
                mosi_q <= 1'b0;
            end else if (fall_s) begin
                mosi_q <= tx_q[DATA_WIDTH-2];
            end

            if (rise_s) begin
                sck_q <= 1'b1;
                rx_q  <= {rx_q[DATA_WIDTH-2:0], miso_sync_q};
            end else if (fall_s) begin
                sck_q <= 1'b0;
            end

            rd_pend_q     <= rise_s && (state_q == DATA) && rd_q && (bit_q == BW'(DATA_WIDTH - 1));
            rdata_valid_q <= rd_pend_q;
            if (rd_pend_q) begin
                rdata_q <= rx_q;
            end
        end
    end

    assign req_ready_o   = req_ready_q;
    assign wdata_ready_o = wdata_ready_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign busy_o        = busy_q;
    assign sck_o         = sck_q;
    assign mosi_o        = mosi_q;
    assign ss_o          = ss_q;

endmodule

// File: tb/tb_spi_bus_master.sv
// Self-checking bench for spi_bus_master: a word-level SPI responder with its own memory and a
// reference memory built from the requested transactions.
module tb_spi_bus_master;
    localparam int CLK_DIV     = 4;
    localparam int TURN_CYCLES = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [13:0] req_addr = 14'h0000;
    logic        req_rd = 1'b0, req_burst = 1'b0;
    logic [7:0]  req_len = 8'h00;
    logic [15:0] wdata = 16'h0000;
    logic        wdata_valid = 1'b0, wdata_ready;
    logic [15:0] rdata;
    logic        rdata_valid, done, err, busy, sck, mosi, ss;
    logic        miso = 1'b0;
`ifdef SPI_MASTER_ABORT_EN
    logic        abort = 1'b0;
`endif

    spi_bus_master #(.CLK_DIV(CLK_DIV), .TURN_CYCLES(TURN_CYCLES)) dut (
        .clk_i(clk), .resetn_i(resetn),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_rd_i(req_rd), .req_burst_i(req_burst), .req_len_i(req_len),
        .wdata_i(wdata), .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready),
        .rdata_o(rdata), .rdata_valid_o(rdata_valid), .done_o(done), .err_o(err), .busy_o(busy),
`ifdef SPI_MASTER_ABORT_EN
        .abort_i(abort),
`endif
        .sck_o(sck), .mosi_o(mosi), .ss_o(ss), .miso_i(miso)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [15:0] smem [0:16383];
    logic [15:0] rmem [0:16383];
    logic [15:0] wq[$];
    logic [15:0] mon_words[$];
    logic [15:0] rd_words[$];
    int          mon_bits = 0, mon_frames = 0, done_cnt = 0;
    logic        last_err = 1'b0;
    time         t16 = 0, t17 = 0;

    // SPI responder: captures MOSI on SCK rise, drives MISO on SCK fall, stores/returns words in smem
    initial begin : responder
        logic        ss_p, sck_p, s_rd;
        logic [15:0] sh;
        logic [13:0] s_addr, idx;
        ss_p = 1'b1; sck_p = 1'b0; s_rd = 1'b0; sh = 16'h0000; s_addr = 14'h0000;
        forever begin
            @(sck or ss);
            if (ss_p && !ss) begin
                mon_frames++;
                mon_bits = 0;
                mon_words.delete();
                miso = 1'($urandom);
            end
            if (!ss && sck && !sck_p) begin
                sh = {sh[14:0], mosi};
                mon_bits++;
                if (mon_bits == 16) t16 = $time;
                if (mon_bits == 17) t17 = $time;
                if (mon_bits % 16 == 0) begin
                    mon_words.push_back(sh);
                    if (mon_bits == 16) begin
                        s_addr = sh[15:2];
                        s_rd   = sh[0];
                    end else if (!s_rd) begin
                        idx = s_addr + 14'(mon_bits / 16 - 2);
                        smem[idx] = sh;
                    end
                end
            end
            if (!ss && !sck && sck_p) begin
                if (s_rd && mon_bits >= 16) begin
                    idx  = s_addr + 14'((mon_bits - 16) / 16);
                    miso = smem[idx][15 - ((mon_bits - 16) % 16)];
                end else begin
                    miso = 1'($urandom);
                end
            end
            ss_p = ss;
            sck_p = sck;
        end
    end

    initial begin : bus_monitor
        forever begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                last_err = err;
            end
            if (rdata_valid) rd_words.push_back(rdata);
        end
    end

    task automatic run_txn(input logic [13:0] addr, input logic rd, input logic burst,
                           input logic [7:0] len, input int stall_word, input int stall_cyc);
        int          n, widx, stall, stall_bad, cyc, d0, f0;
        logic [13:0] a;
        logic [15:0] exp_words[$];
        logic [15:0] exp_rd[$];
        n = burst ? int'(len) + 1 : 1;
        exp_words.push_back({addr, burst, rd});
        for (int i = 0; i < n; i++) begin
            a = addr + 14'(i);
            if (rd) begin
                exp_words.push_back(16'h0000);
                exp_rd.push_back(rmem[a]);
            end else begin
                exp_words.push_back(wq[i]);
                rmem[a] = wq[i];
            end
        end
        rd_words.delete();
        d0 = done_cnt;
        f0 = mon_frames;
        @(negedge clk);
        cyc = 0;
        while (req_ready !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("req_ready_idle", req_ready, 1);
        req_addr = addr; req_rd = rd; req_burst = burst; req_len = len; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_len = 8'($urandom);
        check_eq("busy_accept", busy, 1);
        check_eq("ss_low_accept", ss, 0);
        widx = 0; stall = 0; stall_bad = 0; cyc = 0;
        while (done !== 1'b1 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (wdata_valid) begin
                widx++;
                wdata_valid = 1'b0;
            end else if (wdata_ready && widx < n) begin
                if (widx == stall_word && stall < stall_cyc) begin
                    stall++;
                    if (sck !== 1'b0 || ss !== 1'b0) stall_bad++;
                end else begin
                    wdata = wq[widx];
                    wdata_valid = 1'b1;
                end
            end
        end
        check_eq("done_seen", done, 1);
        check_eq("busy_at_done", busy, 0);
        check_eq("req_ready_at_done", req_ready, 0);
        check_eq("ss_at_done", ss, 1);
        @(negedge clk);
        check_eq("req_ready_after_done", req_ready, 1);
        check_eq("done_one_cycle", done, 0);
        @(negedge clk);
        check_eq("done_count", 32'(done_cnt - d0), 1);
        check_eq("err_at_done", last_err, 0);
        check_eq("frame_count", 32'(mon_frames - f0), 1);
        check_eq("sck_rises", 32'(mon_bits), 32'(16 * (n + 1)));
        check_eq("mosi_word_count", 32'(mon_words.size()), 32'(n + 1));
        for (int i = 0; i < n + 1 && i < mon_words.size(); i++)
            check_eq($sformatf("mosi_word%0d", i), mon_words[i], exp_words[i]);
        check_eq("rdata_count", 32'(rd_words.size()), rd ? 32'(n) : 32'd0);
        for (int i = 0; i < exp_rd.size() && i < rd_words.size(); i++)
            check_eq($sformatf("rdata%0d", i), rd_words[i], exp_rd[i]);
        if (rd) check_eq("turn_gap", 32'(t17 - t16), 32'((2 * CLK_DIV + TURN_CYCLES) * 10));
        if (!rd && stall_cyc > 0 && stall_word < n) begin
            check_eq("stall_len", 32'(stall), 32'(stall_cyc));
            check_eq("stall_pins", 32'(stall_bad), 0);
        end
    endtask

    task automatic reset_mid();
        int cyc, d0;
        d0 = done_cnt;
        @(negedge clk);
        req_addr = 14'h0155; req_rd = 1'b0; req_burst = 1'b0; req_len = 8'h00; req_valid = 1'b1;
        wdata = 16'h1357; wdata_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0;
        while (mon_bits < 25 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("rst_reach_bit9", 32'(mon_bits), 32'd25);
        wdata_valid = 1'b0;
        resetn = 1'b0;
        #1;
        check_eq("rst_ss", ss, 1);
        check_eq("rst_sck", sck, 0);
        check_eq("rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_no_done", 32'(done_cnt - d0), 0);
        check_eq("rst_req_ready", req_ready, 1);
    endtask

    initial begin : stimulus
        logic [15:0] v;
        int          n;
        for (int i = 0; i < 16384; i++) begin
            v = 16'($urandom);
            smem[i] = v;
            rmem[i] = v;
        end
        repeat (3) @(negedge clk);
        check_eq("reset_ss", ss, 1);
        check_eq("reset_sck", sck, 0);
        check_eq("reset_mosi", mosi, 0);
        check_eq("reset_rdata", rdata, 0);
        check_eq("reset_rvalid", rdata_valid, 0);
        check_eq("reset_wready", wdata_ready, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_err", err, 0);
        resetn = 1'b1;
        @(negedge clk);
        check_eq("reset_req_ready", req_ready, 1);

        wq = '{16'hBEEF};
        run_txn(14'h0123, 1'b0, 1'b0, 8'h00, 0, 0);
        check_eq("t1_cmd", mon_words[0], 16'h048C);
        check_eq("t1_data", mon_words[1], 16'hBEEF);

        smem[14'h3FFF] = 16'h1234; rmem[14'h3FFF] = 16'h1234;
        smem[14'h0000] = 16'h5678; rmem[14'h0000] = 16'h5678;
        run_txn(14'h3FFF, 1'b1, 1'b1, 8'h01, 0, 0);
        check_eq("t2_cmd", mon_words[0], 16'hFFFF);
        check_eq("t2_rd0", rd_words[0], 16'h1234);
        check_eq("t2_rd1", rd_words[1], 16'h5678);

        wq = '{16'hA5A5, 16'h5A5A, 16'hFFFF};
        run_txn(14'h0200, 1'b0, 1'b1, 8'h02, 1, 50);

        wq = '{16'h0F0F};
        run_txn(14'h0300, 1'b0, 1'b0, 8'h07, 0, 0);

        reset_mid();

        wq = '{16'hCAFE};
        run_txn(14'h0040, 1'b0, 1'b0, 8'h00, 0, 0);
        run_txn(14'h0040, 1'b1, 1'b0, 8'h00, 0, 0);
        check_eq("t6_loopback", rd_words[0], 16'hCAFE);

        for (int t = 0; t < 12; t++) begin
            logic       rd, burst;
            logic [7:0] len;
            rd    = 1'($urandom);
            burst = 1'($urandom);
            len   = burst ? 8'($urandom_range(0, 3)) : 8'($urandom);
            n     = burst ? int'(len) + 1 : 1;
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
            run_txn(14'($urandom), rd, burst, len, $urandom_range(0, n - 1), $urandom_range(0, 20));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
